// File: rtl/adder_pkg.sv
// Shared constants for the ripple-carry adder family: the per-gate
// propagation delay used by the bit cells and the datapath word width.
`timescale 10ps/1ps

package adder_pkg;

  // Propagation delay of each primitive gate, in timescale units (10ps).
  localparam int DEFAULT_GATE_DELAY = 5;

  // Word width of the ripple adder and the ALU built on top of it.
  localparam int WORD_WIDTH = 64;

endpackage : adder_pkg

// File: rtl/half_adder_1bit.sv
// Half adder built from gate primitives: s = x ^ y, c = x & y.
// Each gate carries GATE_DELAY so the ripple chain shows realistic timing.
`timescale 10ps/1ps

module half_adder_1bit
  import adder_pkg::*;
#(
  parameter int GATE_DELAY = DEFAULT_GATE_DELAY
) (
  input  logic x,
  input  logic y,
  output wire  s,
  output wire  c
);

  xor #(GATE_DELAY) gXor (s, x, y);
  and #(GATE_DELAY) gAnd (c, x, y);

endmodule : half_adder_1bit

// File: rtl/full_adder_1bit.sv
// Single-bit full adder: the ripple-carry cell of the 64-bit adder.
// Sum and carry are purely combinational (two half adders plus an OR),
// so a long chain settles without any clocking. An optional register
// stage keeps copies of sum and carry for pipelined use and debug.
`timescale 10ps/1ps

module full_adder_1bit
  import adder_pkg::*;
#(
  parameter int GATE_DELAY = DEFAULT_GATE_DELAY,
  parameter bit REG_OUT    = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic a,
  input  logic b,
  input  logic Cin,
  input  logic en,
  output wire  out,
  output wire  Cout,
  output logic out_q,
  output logic Cout_q
);

  wire halfSum;
  wire lowCarry;
  wire highCarry;

  // First stage adds the two operand bits.
  half_adder_1bit #(.GATE_DELAY(GATE_DELAY)) uHalfLow (
    .x (a),
    .y (b),
    .s (halfSum),
    .c (lowCarry)
  );

  // Second stage folds in the incoming carry; its sum is the final sum bit.
  half_adder_1bit #(.GATE_DELAY(GATE_DELAY)) uHalfHigh (
    .x (halfSum),
    .y (Cin),
    .s (out),
    .c (highCarry)
  );

  // At most one of the two half-adder carries can be set, so OR merges them.
  or #(GATE_DELAY) gCarryOr (Cout, lowCarry, highCarry);

  generate
    if (REG_OUT) begin : gRegOut
      logic sum_q;
      logic carry_q;
      logic sum_d;
      logic carry_d;

      // Load the live sum/carry when enabled, otherwise hold the last value.
      always_comb begin
        sum_d   = sum_q;
        carry_d = carry_q;
        if (en) begin
          sum_d   = out;
          carry_d = Cout;
        end
      end

      // Observation registers; reset clears them immediately, independent of clk.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          sum_q   <= 1'b0;
          carry_q <= 1'b0;
        end else begin
          sum_q   <= sum_d;
          carry_q <= carry_d;
        end
      end

      assign out_q  = sum_q;
      assign Cout_q = carry_q;
    end else begin : gNoRegOut
      assign out_q  = 1'b0;
      assign Cout_q = 1'b0;
    end
  endgenerate

endmodule : full_adder_1bit

// File: tb/tb_full_adder_1bit.sv
// Testbench for full_adder_1bit: directed vectors feed a scoreboard queue,
// and a separate monitor pops each expectation and compares it against the
// DUT when the stimulus side signals that outputs are ready to sample.
`timescale 10ps/1ps

module tb_full_adder_1bit;
  import adder_pkg::*;

  localparam int GD = DEFAULT_GATE_DELAY;
  localparam int W  = WORD_WIDTH;

  logic clk;
  logic reset;
  logic a;
  logic b;
  logic cin;
  logic en;
  wire  out;
  wire  cout;
  logic outQ;
  logic coutQ;

  logic [W-1:0] chainA;
  logic [W-1:0] chainB;
  wire  [W-1:0] chainSum;
  wire  [W:0]   chainCarry;
  logic [W-1:0] chainOutQ;
  logic [W-1:0] chainCoutQ;

  typedef struct {
    string        name;
    int           sel;
    logic [63:0]  exp;
  } entry_t;

  entry_t sb[$];
  event   sampleEv;
  int     errors = 0;
  int     checks = 0;

  full_adder_1bit #(.GATE_DELAY(GD), .REG_OUT(1'b1)) dut (
    .clk    (clk),
    .reset  (reset),
    .a      (a),
    .b      (b),
    .Cin    (cin),
    .en     (en),
    .out    (out),
    .Cout   (cout),
    .out_q  (outQ),
    .Cout_q (coutQ)
  );

  assign chainCarry[0] = 1'b0;

  generate
    for (genvar gi = 0; gi < W; gi++) begin : gChain
      full_adder_1bit #(.GATE_DELAY(GD), .REG_OUT(1'b0)) uCell (
        .clk    (clk),
        .reset  (reset),
        .a      (chainA[gi]),
        .b      (chainB[gi]),
        .Cin    (chainCarry[gi]),
        .en     (1'b0),
        .out    (chainSum[gi]),
        .Cout   (chainCarry[gi+1]),
        .out_q  (chainOutQ[gi]),
        .Cout_q (chainCoutQ[gi])
      );
    end
  endgenerate

  // Free-running clock, 1 ns period.
  initial begin
    clk = 1'b0;
    forever #50 clk = ~clk;
  end

  // Monitor: whenever the stimulus side says outputs are settled, drain the queue.
  initial begin
    entry_t       e;
    logic [63:0]  actual;
    forever begin
      @(sampleEv);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        case (e.sel)
          0:       actual = {62'd0, out, cout};
          1:       actual = {62'd0, outQ, coutQ};
          2:       actual = chainSum;
          default: actual = {63'd0, |{chainOutQ, chainCoutQ}};
        endcase
        checks++;
        if (actual !== e.exp) begin
          errors++;
          $display("[TB] FAIL %s: got %h expected %h", e.name, actual, e.exp);
        end
      end
    end
  end

  task automatic applyStimulus(input logic va, input logic vb, input logic vc);
    a   = va;
    b   = vb;
    cin = vc;
  endtask

  task automatic checkOutput(input string name, input int sel, input logic [63:0] exp);
    entry_t e;
    e.name = name;
    e.sel  = sel;
    e.exp  = exp;
    sb.push_back(e);
    ->sampleEv;
    #1;
  endtask

  initial begin
    logic [7:0]   sumTable;
    logic [7:0]   carryTable;
    logic [2:0]   vec;
    logic [63:0]  chainVecA [6];
    logic [63:0]  chainVecB [6];
    logic [63:0]  chainExp  [6];

    sumTable   = 8'b1001_0110;
    carryTable = 8'b1110_1000;

    chainVecA[0] = 64'h1;                 chainVecB[0] = 64'h1;                 chainExp[0] = 64'h2;
    chainVecA[1] = 64'h0;                 chainVecB[1] = 64'h0;                 chainExp[1] = 64'h0;
    chainVecA[2] = 64'hFFFF_FFFF_FFFF_FFFF; chainVecB[2] = 64'hFFFF_FFFF_FFFF_FFFF; chainExp[2] = 64'hFFFF_FFFF_FFFF_FFFE;
    chainVecA[3] = 64'h5000_0000_0000_0000; chainVecB[3] = 64'hC000_0000_0000_0000; chainExp[3] = 64'h1000_0000_0000_0000;
    chainVecA[4] = 64'h3000_0000_0000_0000; chainVecB[4] = 64'h6000_0000_0000_0000; chainExp[4] = 64'h9000_0000_0000_0000;
    chainVecA[5] = 64'hFFFF_FFFF_FFFF_FFFF; chainVecB[5] = 64'h1;                 chainExp[5] = 64'h0;

    reset  = 1'b1;
    en     = 1'b0;
    chainA = '0;
    chainB = '0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    #(3*GD + 1);
    checkOutput("reset_regs", 1, 64'd0);

    applyStimulus(1'b1, 1'b1, 1'b0);
    #(3*GD + 1);
    checkOutput("comb_in_reset", 0, 64'b01);
    en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("reset_beats_en", 1, 64'd0);
    checkOutput("comb_still_valid", 0, 64'b01);

    reset = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    checkOutput("reg_load_101", 1, 64'b01);

    en = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("reg_hold", 1, 64'b01);
    checkOutput("comb_000_after_hold", 0, 64'b00);

    for (int i = 0; i < 8; i++) begin
      vec = 3'(i);
      applyStimulus(vec[2], vec[1], vec[0]);
      #(3*GD + 1);
      checkOutput($sformatf("truth_%b", vec), 0, {62'd0, sumTable[i], carryTable[i]});
    end

    applyStimulus(1'b1, 1'b0, 1'b0);
    #(3*GD + 1);
    checkOutput("timing_pre", 0, 64'b10);
    cin = 1'b1;
    #(2*GD + 1);
    checkOutput("timing_cin_rise", 0, 64'b01);
    #(4*GD);
    checkOutput("timing_settled", 0, 64'b01);

    @(negedge clk);
    en = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("reg_load_100", 1, 64'b10);
    #10;
    reset = 1'b1;
    #1;
    checkOutput("async_reset_clear", 1, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    en    = 1'b0;

    for (int i = 0; i < 6; i++) begin
      chainA = chainVecA[i];
      chainB = chainVecB[i];
      #100000;
      checkOutput($sformatf("chain_%0d", i), 2, chainExp[i]);
    end
    checkOutput("chain_regs_tied_zero", 3, 64'd0);

    #1;
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_full_adder_1bit
